// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract unit: each stage resolves one CW-bit chunk and
// forwards its carry, the partial result and the not-yet-used operand chunks.
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] sum_out,
  output logic             car_out,
  output logic             ovf_out,
  output logic             valid_out,
  input  logic             ready_in
);

  localparam int CW = WIDTH / STAGES;

  logic             adv;
  logic [WIDTH-1:0] b_cond;
  logic             cy0;

  // Subtraction is A + ~B + 1, so the carry-in is forced high and c_in ignored.
  always_comb begin
    adv    = ~valid_out | ready_in;
    b_cond = sub_in ? ~b_in : b_in;
    cy0    = sub_in | c_in;
  end

  assign ready_out = adv;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int IW = WIDTH - gi * CW;  // operand bits entering this stage
      localparam int RW = (gi + 1) * CW;    // result bits known after this stage

      logic          v_i;
      logic          cy_i;
      logic [IW-1:0] a_i;
      logic [IW-1:0] b_i;
      logic [RW-1:0] r_new;
      logic [CW-1:0] s;
      logic          co;
      logic          ld;

      logic          v_q, v_d;
      logic          cy_q, cy_d;
      logic [RW-1:0] r_q, r_d;

      if (gi == 0) begin : g_src
        assign v_i   = valid_in;
        assign a_i   = a_in;
        assign b_i   = b_cond;
        assign cy_i  = cy0;
        assign r_new = s;
      end else begin : g_src
        assign v_i   = g_stage[gi-1].v_q;
        assign a_i   = g_stage[gi-1].g_fwd.a_q;
        assign b_i   = g_stage[gi-1].g_fwd.b_q;
        assign cy_i  = g_stage[gi-1].cy_q;
        assign r_new = {s, g_stage[gi-1].r_q};
      end

      assign {co, s} = {1'b0, a_i[CW-1:0]} + {1'b0, b_i[CW-1:0]} + {{CW{1'b0}}, cy_i};
      assign ld      = adv & v_i;

      // Data only loads for a real operation, so a bubble leaves the last result visible.
      always_comb begin
        v_d  = adv ? v_i : v_q;
        r_d  = ld ? r_new : r_q;
        cy_d = ld ? co : cy_q;
      end

      always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
          v_q  <= 1'b0;
          cy_q <= 1'b0;
          r_q  <= '0;
        end else begin
          v_q  <= v_d;
          cy_q <= cy_d;
          r_q  <= r_d;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [IW-CW-1:0] a_q, a_d;
        logic [IW-CW-1:0] b_q, b_d;

        always_comb begin
          a_d = ld ? a_i[IW-1:CW] : a_q;
          b_d = ld ? b_i[IW-1:CW] : b_q;
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) begin
            a_q <= '0;
            b_q <= '0;
          end else begin
            a_q <= a_d;
            b_q <= b_d;
          end
        end
      end else begin : g_last
        logic ov_q, ov_d;

        // Carry into the MSB is recovered as a^b^sum at that bit.
        always_comb begin
          ov_d = ld ? (co ^ a_i[CW-1] ^ b_i[CW-1] ^ s[CW-1]) : ov_q;
        end

        always_ff @(posedge clk_in or negedge rst_n_in) begin
          if (!rst_n_in) ov_q <= 1'b0;
          else           ov_q <= ov_d;
        end
      end
    end
  endgenerate

  assign valid_out = g_stage[STAGES-1].v_q;
  assign sum_out   = g_stage[STAGES-1].r_q;
  assign car_out   = g_stage[STAGES-1].cy_q;
  assign ovf_out   = g_stage[STAGES-1].g_last.ov_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4): vector table, streaming,
// downstream stall and asynchronous mid-stream reset.
module tb_pipelined_adder;
  localparam int WIDTH  = 16;
  localparam int STAGES = 4;

  logic             clk_in = 1'b0;
  logic             rst_n_in;
  logic [WIDTH-1:0] a_in, b_in;
  logic             c_in, sub_in, valid_in;
  logic             ready_out;
  logic [WIDTH-1:0] sum_out;
  logic             car_out, ovf_out, valid_out;
  logic             ready_in;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .sub_in    (sub_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .sum_out   (sum_out),
    .car_out   (car_out),
    .ovf_out   (ovf_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] sum;
    logic        car;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  logic [15:0] held;
  int          sent, got, stall_left;
  bit          stall_done;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vecs[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

    rst_n_in = 1'b0;
    a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0; valid_in = 1'b0;
    ready_in = 1'b1;
    tick();
    tick();
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_sum",   {16'd0, sum_out},   32'd0);
    check("rst_car",   {31'd0, car_out},   32'd0);
    check("rst_ovf",   {31'd0, ovf_out},   32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd1);
    rst_n_in = 1'b1;
    tick();

    // Single operations: exact latency, result, then bubble with held data.
    for (int i = 0; i < 10; i++) begin
      a_in = vecs[i].a; b_in = vecs[i].b; c_in = vecs[i].cin; sub_in = vecs[i].sub;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      tick();
      check($sformatf("v%0d_early_valid", i), {31'd0, valid_out}, 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), {31'd0, valid_out}, 32'd1);
      check($sformatf("v%0d_sum", i),   {16'd0, sum_out},   {16'd0, vecs[i].sum});
      check($sformatf("v%0d_car", i),   {31'd0, car_out},   {31'd0, vecs[i].car});
      check($sformatf("v%0d_ovf", i),   {31'd0, ovf_out},   {31'd0, vecs[i].ovf});
      $display("vec %0d: a=%h b=%h sub=%0d cin=%0d -> sum=%h car=%0d ovf=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, sum_out, car_out, ovf_out);
      tick();
      check($sformatf("v%0d_one_cycle", i), {31'd0, valid_out}, 32'd0);
      check($sformatf("v%0d_hold_sum", i),  {16'd0, sum_out},   {16'd0, vecs[i].sum});
    end

    // Back-to-back stream: A=i, B=i<<8.
    sub_in = 1'b0; c_in = 1'b0;
    for (int cyc = 0; cyc < 13; cyc++) begin
      valid_in = (cyc < 8);
      a_in = 16'(cyc + 1);
      b_in = 16'((cyc + 1) << 8);
      #1;
      check($sformatf("stream_ready_%0d", cyc), {31'd0, ready_out}, 32'd1);
      tick();
      if (cyc >= 3 && cyc <= 10) begin
        exp_v = 16'((cyc - 2) * 257);
        check($sformatf("stream_valid_%0d", cyc), {31'd0, valid_out}, 32'd1);
        check($sformatf("stream_sum_%0d", cyc),   {16'd0, sum_out},   {16'd0, exp_v});
        $display("stream item %0d: sum=%h", cyc - 2, sum_out);
      end else begin
        check($sformatf("stream_gap_%0d", cyc), {31'd0, valid_out}, 32'd0);
      end
    end
    valid_in = 1'b0;

    // Stall: 10 items with valid_in held, downstream stalls 3 cycles at first result.
    sent = 1; got = 0; stall_left = 0; stall_done = 1'b0; held = '0;
    a_in = 16'h0101; b_in = 16'h0010; valid_in = 1'b1; ready_in = 1'b1;
    for (int cyc = 0; cyc < 60 && got < 10; cyc++) begin
      #1;
      if (stall_left > 0) begin
        check("stall_ready", {31'd0, ready_out}, 32'd0);
        check("stall_valid", {31'd0, valid_out}, 32'd1);
        check("stall_sum",   {16'd0, sum_out},   {16'd0, held});
      end else begin
        check("flow_ready", {31'd0, ready_out}, 32'd1);
      end
      if (valid_out && ready_in) begin
        exp_v = exp_q.pop_front();
        check($sformatf("flow_sum_%0d", got), {16'd0, sum_out}, {16'd0, exp_v});
        $display("stall item %0d: sum=%h", got, sum_out);
        got++;
      end
      if (valid_in && ready_out) begin
        exp_q.push_back(16'(sent * 257 + 16));
        sent++;
      end
      tick();
      if (stall_left > 0) stall_left--;
      else if (!stall_done && valid_out) begin
        stall_left = 3;
        stall_done = 1'b1;
        held = sum_out;
      end
      ready_in = (stall_left == 0);
      valid_in = (sent <= 10);
      a_in = 16'(sent * 257);
    end
    check("stall_all_received", got, 32'd10);
    valid_in = 1'b0;
    ready_in = 1'b1;

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) begin
      a_in = 16'hFFFF; b_in = 16'(i + 2); sub_in = 1'b0; c_in = 1'b0;
      valid_in = 1'b1;
      tick();
    end
    check("pre_rst_valid", {31'd0, valid_out}, 32'd1);
    #3;
    rst_n_in = 1'b0;
    #1;
    check("arst_valid", {31'd0, valid_out}, 32'd0);
    check("arst_sum",   {16'd0, sum_out},   32'd0);
    check("arst_car",   {31'd0, car_out},   32'd0);
    check("arst_ovf",   {31'd0, ovf_out},   32'd0);
    valid_in = 1'b0;
    @(posedge clk_in);
    #2;
    rst_n_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("post_rst_idle_%0d", i), {31'd0, valid_out}, 32'd0);
    end
    a_in = 16'h0003; b_in = 16'h0004; valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    tick();
    tick();
    check("post_rst_early", {31'd0, valid_out}, 32'd0);
    tick();
    check("post_rst_valid", {31'd0, valid_out}, 32'd1);
    check("post_rst_sum",   {16'd0, sum_out},   32'h0007);
    $display("post-reset item: sum=%h", sum_out);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
